// File: rtl/fix_rx_msg_fifo.sv
// fix_rx_msg_fifo
//   Store-and-forward byte FIFO between the TCP offload engine and fix_engine.
//   Inbound FIX bytes are written speculatively. A message becomes visible to
//   the reader only once its "SOH 10=<digits> SOH" trailer has been seen.
//   A partial message that fills the whole buffer is discarded up to the next
//   closing SOH.
//
//   Optional build macro: FIX_RX_CKSUM_CHK_EN
//     When defined, each message's 3-digit checksum field is compared with the
//     8-bit byte sum up to and including the SOH that precedes "10=".
//     A message that fails the check is discarded and cksum_err_o pulses.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   toe_byte_i     inbound byte from the TOE
//   toe_valid_i    toe_byte_i is valid
//   toe_ready_o    a byte can be accepted (low while in reset)
//   eng_message_o  show-ahead byte to fix_engine
//   eng_valid_o    eng_message_o holds committed data
//   eng_ready_i    fix_engine consumes eng_message_o this cycle
//   eng_last_o     eng_message_o is the closing SOH of a message
//   new_message_o  at least one complete message is buffered
//   overflow_o     one-cycle pulse when an oversize partial message is dropped
//   cksum_err_o    one-cycle pulse when a message fails the checksum check
module fix_rx_msg_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned PTR_W = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] toe_byte_i,
  input  logic       toe_valid_i,
  output logic       toe_ready_o,
  output logic [7:0] eng_message_o,
  output logic       eng_valid_o,
  input  logic       eng_ready_i,
  output logic       eng_last_o,
  output logic       new_message_o,
  output logic       overflow_o,
  output logic       cksum_err_o
);

  localparam int unsigned      AW       = PTR_W - 1;
  localparam logic [PTR_W-1:0] FULL_OCC = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [7:0]       SOH      = 8'h01;

  typedef enum logic [2:0] {
    S_BODY,
    S_T1,
    S_T0,
    S_EQ,
    S_CKS,
    S_DROP
  } state_t;

  logic [8:0]       mem [DEPTH];
  logic [8:0]       rd_word;
  logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr, occ;
  logic             full, wr_fire, rd_fire, ovf_hit, closing;
  state_t           state, drop_sub, trk, trk_nxt;

  // Trailer recogniser shared by the normal path and the drop path.
  function automatic state_t trl_next(input state_t s, input logic [7:0] b);
    state_t n;
    n = S_BODY;
    case (s)
      S_BODY:  n = (b == SOH) ? S_T1 : S_BODY;
      S_T1:    n = (b == 8'h31) ? S_T0  : ((b == SOH) ? S_T1 : S_BODY);
      S_T0:    n = (b == 8'h30) ? S_EQ  : ((b == SOH) ? S_T1 : S_BODY);
      S_EQ:    n = (b == 8'h3d) ? S_CKS : ((b == SOH) ? S_T1 : S_BODY);
      S_CKS:   n = (b == SOH) ? S_BODY : S_CKS;
      default: n = S_BODY;
    endcase
    return n;
  endfunction

  assign occ           = wr_ptr - rd_ptr;
  assign full          = (occ == FULL_OCC);
  assign toe_ready_o   = rst & ~full;
  assign eng_valid_o   = (rd_ptr != commit_ptr);
  assign new_message_o = eng_valid_o;
  assign rd_word       = mem[rd_ptr[AW-1:0]];
  // Gated so the data outputs read 0 whenever nothing committed is presented.
  assign eng_message_o = eng_valid_o ? rd_word[7:0] : '0;
  assign eng_last_o    = eng_valid_o & rd_word[8];

  assign wr_fire = toe_valid_i & toe_ready_o;
  assign rd_fire = eng_valid_o & eng_ready_i;
  // Full with nothing committed: the stored partial message can never complete.
  assign ovf_hit = full & (commit_ptr == rd_ptr);

  always_comb begin
    trk     = (state == S_DROP) ? drop_sub : state;
    trk_nxt = trl_next(trk, toe_byte_i);
  end

  assign closing = (trk == S_CKS) && (toe_byte_i == SOH);

`ifdef FIX_RX_CKSUM_CHK_EN
  logic [7:0] run_sum, snap;
  logic [9:0] cks_val;
  logic [2:0] cks_cnt;
  logic       dig_ok, is_digit, cks_ok;

  assign is_digit = (toe_byte_i >= 8'h30) && (toe_byte_i <= 8'h39);
  assign cks_ok   = dig_ok && (cks_cnt == 3'd3) && (cks_val == {2'b00, snap});
`else
  assign cksum_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_fire && (state != S_DROP)) begin
      mem[wr_ptr[AW-1:0]] <= {closing, toe_byte_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      state       <= S_BODY;
      drop_sub    <= S_BODY;
      overflow_o  <= 1'b0;
`ifdef FIX_RX_CKSUM_CHK_EN
      cksum_err_o <= 1'b0;
      run_sum     <= '0;
      snap        <= '0;
      cks_val     <= '0;
      cks_cnt     <= '0;
      dig_ok      <= 1'b0;
`endif
    end else begin
      overflow_o <= 1'b0;
`ifdef FIX_RX_CKSUM_CHK_EN
      cksum_err_o <= 1'b0;
`endif
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      if (ovf_hit) begin
        // Keep tracking the trailer from where the discarded message left off.
        wr_ptr     <= commit_ptr;
        drop_sub   <= state;
        state      <= S_DROP;
        overflow_o <= 1'b1;
      end else if (wr_fire) begin
        if (state == S_DROP) begin
          if (closing) begin
            state <= S_BODY;
          end else begin
            drop_sub <= trk_nxt;
          end
        end else begin
          state <= trk_nxt;
          if (closing) begin
`ifdef FIX_RX_CKSUM_CHK_EN
            if (cks_ok) begin
              commit_ptr <= wr_ptr + PTR_ONE;
              wr_ptr     <= wr_ptr + PTR_ONE;
            end else begin
              wr_ptr      <= commit_ptr;
              cksum_err_o <= 1'b1;
            end
`else
            commit_ptr <= wr_ptr + PTR_ONE;
            wr_ptr     <= wr_ptr + PTR_ONE;
`endif
          end else begin
            wr_ptr <= wr_ptr + PTR_ONE;
          end
        end

`ifdef FIX_RX_CKSUM_CHK_EN
        if (closing) begin
          run_sum <= '0;
        end else if (state != S_DROP) begin
          run_sum <= run_sum + toe_byte_i;
          // Snapshot includes the SOH itself; the latest one before "10=" wins.
          if (toe_byte_i == SOH) begin
            snap <= run_sum + toe_byte_i;
          end
          if ((trk == S_EQ) && (toe_byte_i == 8'h3d)) begin
            cks_val <= '0;
            cks_cnt <= '0;
            dig_ok  <= 1'b1;
          end
          if (trk == S_CKS) begin
            cks_val <= (cks_val * 10'd10) + {2'b00, toe_byte_i - 8'h30};
            if (cks_cnt != 3'd4) begin
              cks_cnt <= cks_cnt + 3'd1;
            end
            if (!is_digit) begin
              dig_ok <= 1'b0;
            end
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_fix_rx_msg_fifo.sv
module tb_fix_rx_msg_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  // Instance A: default DEPTH=64
  logic [7:0] a_byte = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] a_msg;
  logic       a_vld;
  logic       a_rdy = 1'b0;
  logic       a_last, a_new, a_ovf, a_cerr;

  // Instance B: DEPTH=16 for the overflow case
  logic [7:0] b_byte = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [7:0] b_msg;
  logic       b_vld;
  logic       b_rdy = 1'b0;
  logic       b_last, b_new, b_ovf, b_cerr;

  int checks   = 0;
  int failures = 0;
  int ovf_cnt  = 0;

  logic [7:0] msg_good [9];
  logic [7:0] msg_bad  [9];
  logic [7:0] exp_msg  [9];

  always #5 clk = ~clk;

  fix_rx_msg_fifo u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .toe_byte_i    (a_byte),
    .toe_valid_i   (a_valid),
    .toe_ready_o   (a_ready),
    .eng_message_o (a_msg),
    .eng_valid_o   (a_vld),
    .eng_ready_i   (a_rdy),
    .eng_last_o    (a_last),
    .new_message_o (a_new),
    .overflow_o    (a_ovf),
    .cksum_err_o   (a_cerr)
  );

  fix_rx_msg_fifo #(.DEPTH(16), .PTR_W(5)) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .toe_byte_i    (b_byte),
    .toe_valid_i   (b_valid),
    .toe_ready_o   (b_ready),
    .eng_message_o (b_msg),
    .eng_valid_o   (b_vld),
    .eng_ready_i   (b_rdy),
    .eng_last_o    (b_last),
    .new_message_o (b_new),
    .overflow_o    (b_ovf),
    .cksum_err_o   (b_cerr)
  );

  always @(negedge clk) begin
    if (b_ovf) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the byte was accepted.
  task automatic send(input int unsigned which, input logic [7:0] b);
    int unsigned n;
    logic rdy;
    n = 0;
    if (which == 0) begin a_byte = b; a_valid = 1'b1; end
    else            begin b_byte = b; b_valid = 1'b1; end
    rdy = (which == 0) ? a_ready : b_ready;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
      rdy = (which == 0) ? a_ready : b_ready;
    end
    if (!rdy) check("send_ready_timeout", 32'(rdy), 32'd1);
    @(negedge clk);
    if (which == 0) a_valid = 1'b0;
    else            b_valid = 1'b0;
  endtask

  // Reads nbytes, each compared with exp_msg repeated every 9 bytes.
  task automatic drain(input int unsigned which, input int unsigned nbytes);
    int unsigned got, guard;
    logic v, l, nm;
    logic [7:0] d;
    got = 0;
    guard = 0;
    if (which == 0) a_rdy = 1'b1;
    else            b_rdy = 1'b1;
    while (got < nbytes && guard < 400) begin
      if (which == 0) begin v = a_vld; d = a_msg; l = a_last; nm = a_new; end
      else            begin v = b_vld; d = b_msg; l = b_last; nm = b_new; end
      if (v) begin
        check("drain_byte", 32'(d), 32'(exp_msg[got % 9]));
        check("drain_last", 32'(l), 32'((got % 9) == 8));
        check("drain_new_message", 32'(nm), 32'd1);
        got++;
      end
      @(negedge clk);
      guard++;
    end
    check("drain_count", got, nbytes);
    if (which == 0) begin v = a_vld; nm = a_new; end
    else            begin v = b_vld; nm = b_new; end
    check("drain_empty_valid", 32'(v), 32'd0);
    check("drain_empty_new_message", 32'(nm), 32'd0);
  endtask

  initial begin
    msg_good = '{8'h41, 8'h01, 8'h31, 8'h30, 8'h3d, 8'h30, 8'h36, 8'h36, 8'h01};
    msg_bad  = '{8'h41, 8'h01, 8'h31, 8'h30, 8'h3d, 8'h30, 8'h36, 8'h37, 8'h01};
    exp_msg  = msg_good;

    // Reset state
    #2;
    check("rst_toe_ready", 32'(a_ready), 32'd0);
    check("rst_eng_valid", 32'(a_vld), 32'd0);
    check("rst_new_message", 32'(a_new), 32'd0);
    check("rst_eng_message", 32'(a_msg), 32'd0);
    check("rst_eng_last", 32'(a_last), 32'd0);
    check("rst_overflow", 32'(a_ovf), 32'd0);
    check("rst_cksum_err", 32'(a_cerr), 32'd0);
    check("rst_b_toe_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_toe_ready", 32'(a_ready), 32'd1);

    // Single message, reader always ready
    a_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(0, msg_good[i]);
    check("single_hold_before_soh", 32'(a_vld), 32'd0);
    send(0, msg_good[8]);
    check("single_latency_new_message", 32'(a_new), 32'd1);
    drain(0, 9);

    // Back-to-back, both held until the reader is ready
    a_rdy = 1'b0;
    for (int i = 0; i < 18; i++) send(0, msg_good[i % 9]);
    repeat (3) @(negedge clk);
    check("b2b_buffered_valid", 32'(a_vld), 32'd1);
    check("b2b_buffered_first_byte", 32'(a_msg), 32'h41);
    drain(0, 18);

    // Partial message is held back
    a_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send(0, msg_good[i]);
    repeat (3) @(negedge clk);
    check("partial_hold_valid", 32'(a_vld), 32'd0);
    for (int i = 4; i < 9; i++) send(0, msg_good[i]);
    drain(0, 9);

    // Checksum field mismatch ("067" versus a byte sum of 66)
    a_rdy = 1'b1;
    for (int i = 0; i < 9; i++) send(0, msg_bad[i]);
`ifdef FIX_RX_CKSUM_CHK_EN
    check("cksum_err_pulse", 32'(a_cerr), 32'd1);
    check("cksum_bad_not_released", 32'(a_vld), 32'd0);
    @(negedge clk);
    check("cksum_err_one_cycle", 32'(a_cerr), 32'd0);
    for (int i = 0; i < 9; i++) send(0, msg_good[i]);
    check("cksum_good_no_err", 32'(a_cerr), 32'd0);
    drain(0, 9);
`else
    check("cksum_disabled_no_err", 32'(a_cerr), 32'd0);
    check("cksum_disabled_released", 32'(a_vld), 32'd1);
    exp_msg = msg_bad;
    drain(0, 9);
    exp_msg = msg_good;
`endif

    // Overflow on the 16-entry instance
    for (int i = 0; i < 16; i++) send(1, 8'h42);
    check("ovf_full_backpressure", 32'(b_ready), 32'd0);
    check("ovf_not_yet", 32'(ovf_cnt), 32'd0);
    check("ovf_nothing_valid", 32'(b_vld), 32'd0);
    for (int i = 0; i < 4; i++) send(1, 8'h42);
    check("ovf_single_pulse", 32'(ovf_cnt), 32'd1);
    for (int i = 1; i < 9; i++) send(1, msg_good[i]);
    repeat (2) @(negedge clk);
    check("ovf_dropped_trailer_no_commit", 32'(b_vld), 32'd0);
    for (int i = 0; i < 9; i++) send(1, msg_good[i]);
    drain(1, 9);
    check("ovf_count_final", 32'(ovf_cnt), 32'd1);

    // Reset mid-stream with one message committed
    a_rdy = 1'b0;
    for (int i = 0; i < 9; i++) send(0, msg_good[i]);
    check("midrst_committed_before", 32'(a_vld), 32'd1);
    for (int i = 0; i < 4; i++) send(0, msg_good[i]);
    a_byte = msg_good[4];
    a_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("midrst_toe_ready", 32'(a_ready), 32'd0);
    check("midrst_eng_valid", 32'(a_vld), 32'd0);
    check("midrst_new_message", 32'(a_new), 32'd0);
    check("midrst_eng_message", 32'(a_msg), 32'd0);
    check("midrst_eng_last", 32'(a_last), 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_empty_after", 32'(a_vld), 32'd0);
    check("midrst_ready_after", 32'(a_ready), 32'd1);
    a_rdy = 1'b1;
    for (int i = 0; i < 9; i++) send(0, msg_good[i]);
    drain(0, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
